// File: rtl/adder_stage4_2_accum.sv
// Layer-2 channel accumulation stage: sums NUM_TERMS stage-3 partial sums, adds bias,
// applies ReLU and saturation, and holds the result on a valid/ready output register.
module adder_stage4_2_accum #(
    parameter int unsigned NUM_TERMS = 6,
    parameter int unsigned IN_W      = 15,
    parameter int unsigned OUT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [OUT_W-1:0] bias,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned AccW = 20;
    localparam int unsigned CntW = (NUM_TERMS > 2) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_TERMS - 1);
    localparam logic signed [AccW-1:0] MaxOut = AccW'((2 ** (OUT_W - 1)) - 1);

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [OUT_W-1:0]       out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;

    logic signed [AccW-1:0] in_ext;
    logic signed [AccW-1:0] bias_ext;
    logic signed [AccW-1:0] acc_plus_in;
    logic signed [AccW-1:0] sum_last;
    logic [OUT_W-1:0]       result;
    logic                   take;
    logic                   is_last;
    logic                   complete;
    logic                   accept;

    assign in_ext      = {{(AccW - IN_W){in_data[IN_W-1]}}, in_data};
    assign bias_ext    = {{(AccW - OUT_W){bias[OUT_W-1]}}, bias};
    assign acc_plus_in = acc_q + in_ext;
    // 16 terms of 15 bits plus a 16-bit bias stays well inside 20 signed bits.
    assign sum_last    = acc_plus_in + bias_ext;

    assign take     = in_valid & ~flush;
    assign is_last  = (state_q == StAccum) && (cnt_q == LastCnt);
    assign complete = take & is_last;
    assign accept   = out_valid_q & out_ready;

    always_comb begin
        result = '0;
        if (sum_last[AccW-1]) begin
            result = '0;
        end else if (sum_last > MaxOut) begin
            result = MaxOut[OUT_W-1:0];
        end else begin
            result = sum_last[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAccum;
                    cnt_d   = CntW'(1);
                    acc_d   = in_ext;
                end
                StAccum: begin
                    if (is_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        acc_d = acc_plus_in;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // A completion coinciding with an accept is a back-to-back transfer, not a drop.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (complete && (!out_valid_q || accept)) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (cnt_q != '0);

    hold_until_accepted: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    overrun_sticky: assert property (@(posedge clk) disable iff (reset)
        overrun |=> overrun);

endmodule

// File: tb/tb_adder_stage4_2_accum.sv
// Directed and randomized checks of adder_stage4_2_accum with NUM_TERMS=4.
module tb_adder_stage4_2_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] in_data;
    logic        in_valid;
    logic        flush;
    logic [15:0] bias;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int m_valid;
    int m_data;
    int m_ovr;

    always #5 clk = ~clk;

    adder_stage4_2_accum #(
        .NUM_TERMS(4),
        .IN_W     (15),
        .OUT_W    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .flush    (flush),
        .bias     (bias),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back terms; out_ready is driven only on the last-term cycle.
    task automatic run_group(input int a, input int b, input int c, input int d,
                             input int bs, input logic rdy_last);
        int t[4];
        t = '{a, b, c, d};
        bias = 16'(bs);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = 15'(t[i]);
            out_ready = (i == 3) ? rdy_last : 1'b0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic accept_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq(tag, int'(out_valid), 0);
    endtask

    task automatic rnd_cycle(input logic v, input int data, input logic last, input int r);
        logic rdy;
        logic comp;
        logic acc;
        rdy       = 1'($urandom_range(0, 1));
        in_valid  = v;
        in_data   = 15'(data);
        out_ready = rdy;
        comp      = v & last;
        acc       = (m_valid != 0) & rdy;
        if (comp && (m_valid == 0 || acc)) begin
            m_valid = 1;
            m_data  = r;
        end else if (comp) begin
            m_ovr = 1;
        end else if (acc) begin
            m_valid = 0;
        end
        step();
        check_eq("rnd_valid", int'(out_valid), m_valid);
        if (m_valid != 0) check_eq("rnd_data", int'(out_data), m_data);
        check_eq("rnd_overrun", int'(overrun), m_ovr);
    endtask

    initial begin
        int busy_cycles;
        int t4[4];
        int t[4];
        int bs;
        int sum;
        int r;
        int gaps;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        step();
        step();
        check_eq("reset_valid", int'(out_valid), 0);
        check_eq("reset_data", int'(out_data), 0);
        check_eq("reset_overrun", int'(overrun), 0);
        check_eq("reset_busy", int'(busy), 0);
        reset = 1'b0;

        // Basic group: 100 - 50 + 200 + 7 + 10 = 267, busy for three cycles.
        bias        = 16'(10);
        t4          = '{100, -50, 200, 7};
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 15'(t4[i]);
            step();
            busy_cycles += int'(busy);
        end
        in_valid = 1'b0;
        check_eq("basic_valid", int'(out_valid), 1);
        check_eq("basic_data", int'(out_data), 267);
        check_eq("basic_busy_cycles", busy_cycles, 3);
        accept_result("basic_accept");

        run_group(-300, 20, 20, 20, 0, 1'b0);
        check_eq("relu_data", int'(out_data), 0);
        check_eq("relu_valid", int'(out_valid), 1);
        accept_result("relu_accept");

        run_group(16383, 16383, 16383, 16383, 100, 1'b0);
        check_eq("sat_data", int'(out_data), 32767);
        accept_result("sat_accept");

        run_group(-16384, -16384, -16384, -16384, -32768, 1'b0);
        check_eq("neg_floor_data", int'(out_data), 0);
        accept_result("neg_floor_accept");

        // Second result dropped while first is held.
        run_group(100, -50, 200, 7, 10, 1'b0);
        run_group(1, 1, 1, 2, 0, 1'b0);
        check_eq("ovr_data", int'(out_data), 267);
        check_eq("ovr_valid", int'(out_valid), 1);
        check_eq("ovr_flag", int'(overrun), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("ovr_reset_flag", int'(overrun), 0);

        // Accept on the completion cycle: back-to-back transfer.
        run_group(100, -50, 200, 7, 10, 1'b0);
        run_group(1, 1, 1, 2, 0, 1'b1);
        check_eq("b2b_data", int'(out_data), 5);
        check_eq("b2b_valid", int'(out_valid), 1);
        check_eq("b2b_overrun", int'(overrun), 0);
        accept_result("b2b_accept");

        // Flush after two terms, with a term in the flush cycle that must be ignored.
        bias     = '0;
        in_valid = 1'b1;
        in_data  = 15'(100);
        step();
        step();
        check_eq("pre_flush_busy", int'(busy), 1);
        flush   = 1'b1;
        in_data = 15'(500);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_busy", int'(busy), 0);
        check_eq("flush_valid", int'(out_valid), 0);
        run_group(1, 2, 3, 4, 0, 1'b0);
        check_eq("post_flush_data", int'(out_data), 10);

        // Reset mid-group with a result held.
        in_valid = 1'b1;
        in_data  = 15'(1);
        step();
        step();
        step();
        in_valid = 1'b0;
        check_eq("mid_busy", int'(busy), 1);
        check_eq("mid_held_valid", int'(out_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_reset_valid", int'(out_valid), 0);
        check_eq("mid_reset_data", int'(out_data), 0);
        check_eq("mid_reset_busy", int'(busy), 0);
        check_eq("mid_reset_overrun", int'(overrun), 0);
        run_group(1, 1, 1, 1, 0, 1'b0);
        check_eq("post_reset_data", int'(out_data), 4);
        accept_result("post_reset_accept");

        // Random gaps and random out_ready against a behavioural model.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        m_valid = 0;
        m_data  = 0;
        m_ovr   = 0;
        for (int g = 0; g < 1000; g++) begin
            bs   = int'($urandom_range(0, 4000)) - 2000;
            bias = 16'(bs);
            sum  = bs;
            for (int i = 0; i < 4; i++) begin
                t[i] = int'($urandom_range(0, 16000)) - 8000;
                sum += t[i];
            end
            r = (sum < 0) ? 0 : ((sum > 32767) ? 32767 : sum);
            for (int i = 0; i < 4; i++) begin
                gaps = int'($urandom_range(0, 2));
                for (int k = 0; k < gaps; k++) rnd_cycle(1'b0, 0, 1'b0, 0);
                rnd_cycle(1'b1, t[i], (i == 3), r);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
